ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative RV64M multiply/divide unit in the EX stage.
- Issues the mul/div stall request to the pipeline hazard controller. That controller answers with a PC/Pre_IF/IF_ID stall and an EX_MEM flush until the unit asserts its result.
- Consumes the controller's stall/flush vectors so it can freeze or abort an in-flight operation.

Parameters:
- XLEN, 64, operand/result width.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_i  in  1  EX holds a valid M-extension instruction
- op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- word_i  in  1  *W variant; operands use bits [31:0]
- rs1_i  in  XLEN  operand a
- rs2_i  in  XLEN  operand b
- stall_i  in  6  controller stall vector; bit4 = EX_MEM stall
- flush_i  in  6  controller flush vector; bit3 = ID_EX flush
- stall_req_o  out  1  drives alu_mul_div_valid_ex_i
- result_o  out  XLEN  result, valid when done_o=1
- done_o  out  1  one-cycle completion strobe (held while EX_MEM stalled)

Behaviour:
- Clock/reset: one clock. Reset is synchronous and active-high; ports are named clk and rst.
- Reset: state=IDLE, counter=0, stall_req_o=0, done_o=0, result_o=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - stall_req_o = valid_i (combinational, same cycle as instruction enters EX).
  - On valid_i, latch operands/op/word; go to BUSY.
  - Exception: a special-case divide goes straight to DONE with its preset result.
- BUSY:
  - stall_req_o=1.
  - One radix-2 step per cycle; counter increments.
  - Iterations N = 32 if word_i else XLEN.
  - After step N go to DONE.
- DONE:
  - stall_req_o=0, done_o=1, result_o valid.
  - valid_i ignored (same instruction still present).
  - Next state IDLE, unless stall_i[4]=1: then hold DONE with result stable.
- Latency: a normal op gives N+1 stall cycles; done_o rises N+1 cycles after valid_i first seen (65 for 64-bit, 33 for W).
- Multiply: shift-add on magnitudes.
  - Sign handling: MULH signed x signed; MULHSU signed x unsigned; MULHU unsigned.
  - Final negate when result sign differs.
  - MUL returns low XLEN bits; MULH* return high XLEN bits.
- Divide: restoring division on magnitudes.
  - Quotient takes the dividend's sign xor the divisor's sign; remainder takes the dividend's sign.
- Special cases (resolve in 1 cycle, IDLE->DONE):
  - Divisor 0: quotient all-ones, remainder = dividend.
  - Signed overflow (most-negative / -1): quotient = dividend, remainder 0.
  - Both judged at 32-bit width when word_i=1.
- Word ops:
  - Operands are bits [31:0], sign- or zero-extended per op.
  - Result is bits [31:0] sign-extended to XLEN (including DIVUW/REMUW).
- Flush: flush_i[3]=1 in any state forces IDLE next cycle. No done_o is produced; the counter clears.
- Simultaneous flush and stall: flush wins.
- Reset mid-operation: IDLE next cycle; result discarded.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: multiplies use a single-cycle combinational product. IDLE->DONE directly, so a multiply costs 1 stall cycle. Division is unchanged.
- Undefined: multiplies use the iterative path above.

Decomposition:
- Op-code localparams (funct3 values) and the FSM state encodings go in shared sysconfig.v. No SystemVerilog package.
- One natural sub-module: iter_divider, holding the restoring divide datapath plus its counter; the top keeps the FSM and sign fix-up.

Test Plan:
- MUL 7*(-3), XLEN=64 -> stall_req_o high 65 cycles, then done_o=1, result 0xFFFF_FFFF_FFFF_FFEB.
- MULHU 0xFFFF_FFFF_FFFF_FFFF squared -> result 0xFFFF_FFFF_FFFF_FFFE.
- DIV -7/2 -> quotient 0xFFFF_FFFF_FFFF_FFFD; REM -7/2 -> remainder 0xFFFF_FFFF_FFFF_FFFF.
- DIVU 5/0 -> done after 1 stall cycle, result all-ones; DIV 0x8000_0000_0000_0000/-1 -> result 0x8000_0000_0000_0000.
- DIVUW 0xFFFF_FFFF/1 -> 33 stall cycles, result 0xFFFF_FFFF_FFFF_FFFF.
- Mid-BUSY, pulse flush_i[3] at cycle 10 -> IDLE next cycle, no done_o. Separately, DONE with stall_i[4]=1 for 3 cycles -> done_o/result held 4 cycles.

Source files
------------

// File: rtl/ex_muldiv_unit_iter_divider.sv
// iter_divider: restoring radix-2 divider on unsigned magnitudes, one step per cycle.
// Also owns the iteration counter the top uses to end both multiply and divide.
`include "sysconfig.sv"

module iter_divider #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            start_i,
    input  logic            step_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quo_o,
    output logic [XLEN-1:0] rem_o,
    output logic            last_o
);
    logic [XLEN-1:0]  quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             word_q, word_d;
    logic [XLEN:0]    shl_s;
    logic             ge_s;
    logic [XLEN-1:0]  quo_step_s, rem_step_s;

    // One restoring step; the partial remainder never exceeds 2*divisor-1, so XLEN+1 bits suffice.
    always_comb begin
        shl_s = {rem_q, quo_q[XLEN-1]};
        ge_s  = (shl_s >= {1'b0, dvs_q});
        if (ge_s) begin
            rem_step_s = shl_s[XLEN-1:0] - dvs_q;
            quo_step_s = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_step_s = shl_s[XLEN-1:0];
            quo_step_s = {quo_q[XLEN-2:0], 1'b0};
        end
    end

    assign quo_o  = quo_step_s;
    assign rem_o  = rem_step_s;
    assign last_o = (cnt_q == (word_q ? CNT_W'(31) : CNT_W'(XLEN - 1)));

    // Load, step or clear the datapath; word dividends are left-aligned so the MSB shifts out first.
    always_comb begin
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clr_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (start_i) begin
            quo_d  = word_i ? {dividend_i[31:0], {(XLEN-32){1'b0}}} : dividend_i;
            rem_d  = {XLEN{1'b0}};
            dvs_d  = divisor_i;
            word_d = word_i;
            cnt_d  = {CNT_W{1'b0}};
        end else if (step_i) begin
            quo_d = quo_step_s;
            rem_d = rem_step_s;
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Datapath and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q  <= {XLEN{1'b0}};
            rem_q  <= {XLEN{1'b0}};
            dvs_q  <= {XLEN{1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
            word_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end
endmodule

// File: rtl/sysconfig.sv
// Shared funct3 op codes and FSM state encodings for the ex_muldiv_unit slice.
// Guarded so every file may include it; the declarations live in the compilation unit.
`ifndef EX_MULDIV_SYSCONFIG_SV
`define EX_MULDIV_SYSCONFIG_SV

localparam logic [2:0] OP_MUL    = 3'd0;
localparam logic [2:0] OP_MULH   = 3'd1;
localparam logic [2:0] OP_MULHSU = 3'd2;
localparam logic [2:0] OP_MULHU  = 3'd3;
localparam logic [2:0] OP_DIV    = 3'd4;
localparam logic [2:0] OP_DIVU   = 3'd5;
localparam logic [2:0] OP_REM    = 3'd6;
localparam logic [2:0] OP_REMU   = 3'd7;

typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
} muldiv_state_e;

`endif

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV64M multiply/divide with hazard-controller handshake.
// Optional MULDIV_FAST_MUL_EN replaces the shift-add multiplier with a one-cycle product.
`include "sysconfig.sv"

module ex_muldiv_unit #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [2:0]      op_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [5:0]      stall_i,
    input  logic [5:0]      flush_i,
    output logic            stall_req_o,
    output logic [XLEN-1:0] result_o,
    output logic            done_o
);
    localparam int PW = 2 * XLEN;

    function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
        return {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction

    function automatic logic [XLEN-1:0] mul_pick(input logic [PW-1:0] p, input logic neg,
                                                 input logic [2:0] op, input logic word);
        logic [PW-1:0] s;
        s = neg ? -p : p;
        if (word) return sext_word(s[XLEN-1:0]);
        else if (op == OP_MUL) return s[XLEN-1:0];
        else return s[PW-1:XLEN];
    endfunction

    function automatic logic [XLEN-1:0] div_pick(input logic [XLEN-1:0] quo, input logic [XLEN-1:0] rem,
                                                 input logic neg, input logic rem_op, input logic word);
        logic [XLEN-1:0] v;
        v = rem_op ? rem : quo;
        v = neg ? -v : v;
        return word ? sext_word(v) : v;
    endfunction

    muldiv_state_e   state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic            word_q, word_d, neg_q, neg_d;
    logic [PW-1:0]   mcand_q, mcand_d, prod_q, prod_d, prod_step_s, fast_prod_s;
    logic [XLEN-1:0] mplier_q, mplier_d, result_q, result_d;
    logic            sgn_a_s, sgn_b_s, a_neg_s, b_neg_s, div_zero_s, div_ovf_s, fast_mul_s;
    logic [XLEN-1:0] a_ext_s, b_ext_s, a_mag_s, b_mag_s, special_s;
    logic            div_start_s, div_step_s, div_clr_s, div_last_s;
    logic [XLEN-1:0] div_quo_s, div_rem_s;
    logic            unused_ctrl_s;

    assign unused_ctrl_s = ^{stall_i[5], stall_i[3:0], flush_i[5:4], flush_i[2:0]};

    // Operand decode: signedness, word extension, magnitudes and the divide special cases.
    always_comb begin
        case (op_i)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin sgn_a_s = 1'b1; sgn_b_s = 1'b1; end
            OP_MULHSU:                       begin sgn_a_s = 1'b1; sgn_b_s = 1'b0; end
            OP_MULHU, OP_DIVU, OP_REMU:      begin sgn_a_s = 1'b0; sgn_b_s = 1'b0; end
            default:                         begin sgn_a_s = 1'b0; sgn_b_s = 1'b0; end
        endcase
        if (word_i) begin
            a_ext_s   = sgn_a_s ? sext_word(rs1_i) : {{(XLEN-32){1'b0}}, rs1_i[31:0]};
            b_ext_s   = sgn_b_s ? sext_word(rs2_i) : {{(XLEN-32){1'b0}}, rs2_i[31:0]};
            div_ovf_s = (rs1_i[31:0] == 32'h8000_0000) && (rs2_i[31:0] == 32'hFFFF_FFFF);
        end else begin
            a_ext_s   = rs1_i;
            b_ext_s   = rs2_i;
            div_ovf_s = (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == {XLEN{1'b1}});
        end
        div_ovf_s  = div_ovf_s & sgn_b_s;
        div_zero_s = (b_ext_s == {XLEN{1'b0}});
        a_neg_s    = sgn_a_s & a_ext_s[XLEN-1];
        b_neg_s    = sgn_b_s & b_ext_s[XLEN-1];
        a_mag_s    = a_neg_s ? -a_ext_s : a_ext_s;
        b_mag_s    = b_neg_s ? -b_ext_s : b_ext_s;
        if (div_zero_s) special_s = op_i[1] ? a_ext_s : {XLEN{1'b1}};
        else            special_s = op_i[1] ? {XLEN{1'b0}} : a_ext_s;
    end

`ifdef MULDIV_FAST_MUL_EN
    assign fast_mul_s  = ~op_i[2];
    assign fast_prod_s = {{XLEN{1'b0}}, a_mag_s} * {{XLEN{1'b0}}, b_mag_s};
`else
    assign fast_mul_s  = 1'b0;
    assign fast_prod_s = {PW{1'b0}};
`endif

    assign prod_step_s = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

    iter_divider #(.XLEN(XLEN), .CNT_W(CNT_W)) u_div (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (div_clr_s),
        .start_i    (div_start_s),
        .step_i     (div_step_s),
        .word_i     (word_i),
        .dividend_i (a_mag_s),
        .divisor_i  (b_mag_s),
        .quo_o      (div_quo_s),
        .rem_o      (div_rem_s),
        .last_o     (div_last_s)
    );

    // FSM next state, stall request and datapath control; a flush overrides everything.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        word_d      = word_q;
        neg_d       = neg_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        prod_d      = prod_q;
        result_d    = result_q;
        stall_req_o = 1'b0;
        div_start_s = 1'b0;
        div_step_s  = 1'b0;
        div_clr_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall_req_o = valid_i;
                if (valid_i) begin
                    op_d   = op_i;
                    word_d = word_i;
                    neg_d  = (op_i[2] && op_i[1]) ? a_neg_s : (a_neg_s ^ b_neg_s);
                    if (op_i[2] && (div_zero_s || div_ovf_s)) begin
                        result_d = word_i ? sext_word(special_s) : special_s;
                        state_d  = ST_DONE;
                    end else if (fast_mul_s) begin
                        result_d = mul_pick(fast_prod_s, a_neg_s ^ b_neg_s, op_i, word_i);
                        state_d  = ST_DONE;
                    end else begin
                        div_start_s = 1'b1;
                        mcand_d     = {{XLEN{1'b0}}, a_mag_s};
                        mplier_d    = b_mag_s;
                        prod_d      = {PW{1'b0}};
                        state_d     = ST_BUSY;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                stall_req_o = 1'b1;
                div_step_s  = 1'b1;
                mcand_d     = {mcand_q[PW-2:0], 1'b0};
                mplier_d    = {1'b0, mplier_q[XLEN-1:1]};
                prod_d      = prod_step_s;
                if (div_last_s) begin
                    result_d = op_q[2] ? div_pick(div_quo_s, div_rem_s, neg_q, op_q[1], word_q)
                                       : mul_pick(prod_step_s, neg_q, op_q, word_q);
                    state_d  = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (stall_i[4]) state_d = ST_DONE;
                else            state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (flush_i[3]) begin
            state_d     = ST_IDLE;
            div_clr_s   = 1'b1;
            div_start_s = 1'b0;
            div_step_s  = 1'b0;
        end else begin
            div_clr_s = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= 3'd0;
            word_q   <= 1'b0;
            neg_q    <= 1'b0;
            mcand_q  <= {PW{1'b0}};
            mplier_q <= {XLEN{1'b0}};
            prod_q   <= {PW{1'b0}};
            result_q <= {XLEN{1'b0}};
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            word_q   <= word_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            result_q <= result_d;
        end
    end

    assign done_o   = (state_q == ST_DONE);
    assign result_o = result_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit (hand-computed RV64M results and latencies).
module tb_ex_muldiv_unit;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL64_STALLS = 1;
    localparam int MULW_STALLS  = 1;
`else
    localparam int MUL64_STALLS = 65;
    localparam int MULW_STALLS  = 33;
`endif

    logic        clk = 1'b0;
    logic        rst, valid_i, word_i;
    logic [2:0]  op_i;
    logic [63:0] rs1_i, rs2_i;
    logic [5:0]  stall_i, flush_i;
    logic        stall_req_o, done_o;
    logic [63:0] result_o;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    ex_muldiv_unit dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .op_i(op_i), .word_i(word_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .stall_i(stall_i), .flush_i(flush_i),
        .stall_req_o(stall_req_o), .result_o(result_o), .done_o(done_o)
    );

    // Present one instruction until done_o, counting stall cycles; drops valid_i in the done cycle.
    task automatic issue(input logic [2:0] op, input logic word, input logic [63:0] a, input logic [63:0] b,
                         output int stalls, output logic [63:0] res, output logic got, output logic st_done);
        int c;
        @(negedge clk);
        valid_i = 1'b1; op_i = op; word_i = word; rs1_i = a; rs2_i = b;
        stalls = 0; res = 64'd0; got = 1'b0; st_done = 1'b0; c = 0;
        #1;
        while (!got && c < 300) begin
            if (done_o) begin
                got = 1'b1; res = result_o; st_done = stall_req_o;
            end else begin
                if (stall_req_o) stalls++;
                c++;
                @(negedge clk); #1;
            end
        end
        valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_i = 1'b0; op_i = 3'd0; word_i = 1'b0; rs1_i = 64'd0; rs2_i = 64'd0;
        stall_i = 6'd0; flush_i = 6'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done_o); end
        n_vec++; if (stall_req_o !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall_req_o); end
        n_vec++; if (result_o !== 64'd0) begin n_err++; $display("FAIL reset_result: got %h want 0", result_o); end
        rst = 1'b0;
    endtask

    task automatic test_mul();
        int st; logic [63:0] r; logic g, sd;
        issue(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, st, r, g, sd);
        n_vec++; if (!g || r !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_err++; $display("FAIL mul_7x-3: got %h done=%b want ffffffffffffffeb", r, g); end
        n_vec++; if (st != MUL64_STALLS) begin n_err++; $display("FAIL mul_stalls: got %0d want %0d", st, MUL64_STALLS); end
        n_vec++; if (sd !== 1'b0) begin n_err++; $display("FAIL mul_stall_in_done: got %b want 0", sd); end
        issue(3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, st, r, g, sd);
        n_vec++; if (!g || r !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_err++; $display("FAIL mulhu_max: got %h want fffffffffffffffe", r); end
        issue(3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, st, r, g, sd);
        n_vec++; if (!g || r !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL mulhsu_-1x2: got %h want ffffffffffffffff", r); end
        issue(3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, st, r, g, sd);
        n_vec++; if (!g || r !== 64'd0) begin n_err++; $display("FAIL mulh_-1x-1: got %h want 0", r); end
        issue(3'd0, 1'b1, 64'hDEAD_BEEF_7FFF_FFFF, 64'd2, st, r, g, sd);
        n_vec++; if (!g || r !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_err++; $display("FAIL mulw: got %h want fffffffffffffffe", r); end
        n_vec++; if (st != MULW_STALLS) begin n_err++; $display("FAIL mulw_stalls: got %0d want %0d", st, MULW_STALLS); end
    endtask

    task automatic test_div();
        int st; logic [63:0] r; logic g, sd;
        issue(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, st, r, g, sd);
        n_vec++; if (!g || r !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_err++; $display("FAIL div_-7/2: got %h want fffffffffffffffd", r); end
        n_vec++; if (st != 65) begin n_err++; $display("FAIL div_stalls: got %0d want 65", st); end
        issue(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, st, r, g, sd);
        n_vec++; if (!g || r !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL rem_-7/2: got %h want ffffffffffffffff", r); end
        issue(3'd5, 1'b0, 64'd100, 64'd7, st, r, g, sd);
        n_vec++; if (!g || r !== 64'd14) begin n_err++; $display("FAIL divu_100/7: got %h want e", r); end
        issue(3'd7, 1'b0, 64'd100, 64'd7, st, r, g, sd);
        n_vec++; if (!g || r !== 64'd2) begin n_err++; $display("FAIL remu_100/7: got %h want 2", r); end
        issue(3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, st, r, g, sd);
        n_vec++; if (!g || r !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL remw_-7/2: got %h want ffffffffffffffff", r); end
    endtask

    task automatic test_special();
        int st; logic [63:0] r; logic g, sd;
        issue(3'd5, 1'b0, 64'd5, 64'd0, st, r, g, sd);
        n_vec++; if (!g || r !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL divu_by0: got %h want ffffffffffffffff", r); end
        n_vec++; if (st != 1) begin n_err++; $display("FAIL divu_by0_stalls: got %0d want 1", st); end
        issue(3'd6, 1'b0, 64'd5, 64'd0, st, r, g, sd);
        n_vec++; if (!g || r !== 64'd5) begin n_err++; $display("FAIL rem_by0: got %h want 5", r); end
        issue(3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, st, r, g, sd);
        n_vec++; if (!g || r !== 64'h8000_0000_0000_0000) begin n_err++; $display("FAIL div_ovf: got %h want 8000000000000000", r); end
        n_vec++; if (st != 1) begin n_err++; $display("FAIL div_ovf_stalls: got %0d want 1", st); end
        issue(3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, st, r, g, sd);
        n_vec++; if (!g || r !== 64'd0) begin n_err++; $display("FAIL rem_ovf: got %h want 0", r); end
        issue(3'd4, 1'b1, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, st, r, g, sd);
        n_vec++; if (!g || r !== 64'hFFFF_FFFF_8000_0000) begin n_err++; $display("FAIL divw_ovf: got %h want ffffffff80000000", r); end
        n_vec++; if (st != 1) begin n_err++; $display("FAIL divw_ovf_stalls: got %0d want 1", st); end
    endtask

    task automatic test_word();
        int st; logic [63:0] r; logic g, sd;
        issue(3'd5, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, st, r, g, sd);
        n_vec++; if (!g || r !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL divuw: got %h want ffffffffffffffff", r); end
        n_vec++; if (st != 33) begin n_err++; $display("FAIL divuw_stalls: got %0d want 33", st); end
    endtask

    task automatic test_flush();
        int st; logic [63:0] r; logic g, sd; logic seen;
        @(negedge clk);
        valid_i = 1'b1; op_i = 3'd5; word_i = 1'b0; rs1_i = 64'd100; rs2_i = 64'd7;
        repeat (10) @(negedge clk);
        #1;
        n_vec++; if (stall_req_o !== 1'b1) begin n_err++; $display("FAIL flush_busy_stall: got %b want 1", stall_req_o); end
        flush_i = 6'b001000; valid_i = 1'b0;
        @(negedge clk); #1;
        flush_i = 6'd0;
        n_vec++; if (stall_req_o !== 1'b0 || done_o !== 1'b0) begin n_err++; $display("FAIL flush_idle: stall=%b done=%b want 0 0", stall_req_o, done_o); end
        seen = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (done_o) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_no_done: got %b want 0", seen); end
        issue(3'd5, 1'b0, 64'd100, 64'd7, st, r, g, sd);
        n_vec++; if (!g || r !== 64'd14 || st != 65) begin n_err++; $display("FAIL after_flush: got %h/%0d want e/65", r, st); end
    endtask

    task automatic test_done_hold();
        int st; logic [63:0] r; logic g, sd;
        issue(3'd7, 1'b0, 64'd100, 64'd7, st, r, g, sd);
        n_vec++; if (!g || r !== 64'd2) begin n_err++; $display("FAIL hold_first: got %h want 2", r); end
        stall_i = 6'b010000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            n_vec++;
            if (done_o !== 1'b1 || result_o !== 64'd2 || stall_req_o !== 1'b0) begin
                n_err++; $display("FAIL hold_cycle%0d: done=%b res=%h stall=%b want 1 2 0", k, done_o, result_o, stall_req_o);
            end
        end
        stall_i = 6'd0;
        @(negedge clk); #1;
        n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL hold_release: got %b want 0", done_o); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        @(negedge clk);
        valid_i = 1'b1; op_i = 3'd4; word_i = 1'b0; rs1_i = 64'd50; rs2_i = 64'd3;
        repeat (5) @(negedge clk);
        valid_i = 1'b0; rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        n_vec++; if (stall_req_o !== 1'b0 || done_o !== 1'b0 || result_o !== 64'd0) begin
            n_err++; $display("FAIL reset_mid: stall=%b done=%b res=%h want 0 0 0", stall_req_o, done_o, result_o);
        end
        seen = 1'b0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (done_o) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL reset_mid_no_done: got %b want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_word();
        test_flush();
        test_done_hold();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
